gmii_tx_framer: RTL and testbench

//  Byte-stream to GMII TX framer; sits directly upstream of the GMII->RGMII converter and drives its gmiitxd/gmiitxen/gmiitxer.

---
 rtl/gmii_pkg.sv | 35 +++
 rtl/crc32_d8.sv | 15 +
 rtl/gmii_tx_framer.sv | 242 ++++++++++++++++++++++++
 tb/tb_gmii_tx_framer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gmii_pkg.sv
// Shared GMII framing constants, transmit FSM state type and the byte-wide
// reflected CRC-32 step used by both the TX framer and the RX checker.
package gmii_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_SFD  = 3'd2,
    ST_DATA = 3'd3,
    ST_PAD  = 3'd4,
    ST_FCS  = 3'd5,
    ST_IFG  = 3'd6
  } tx_state_t;

  // One byte of the LSB-first (reflected) CRC-32 shift register.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      if (c[0]) begin
        c = (c >> 1) ^ CRC_POLY;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Combinational CRC-32 next-state for one data byte per clock.
module crc32_d8
  import gmii_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  // Fold one byte into the running CRC.
  always_comb begin
    crc_out = crc32_byte(crc_in, data);
  end

endmodule

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: wraps an upstream payload stream with preamble, SFD,
// zero pad to minimum length and FCS, then holds the inter-frame gap.
// Every GMII output is a register loaded from the decision taken in the
// current state, so a state's byte reaches the wire one edge after it.
module gmii_tx_framer
  import gmii_pkg::*;
#(
  parameter int unsigned IFG_BYTES   = 12,
  parameter int unsigned MIN_PAYLOAD = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] txdata,
  input  logic       txvalid,
  input  logic       txlast,
  input  logic       txerr,
  output logic       txready,
  output logic [7:0] gmiitxd,
  output logic       gmiitxen,
  output logic       gmiitxer,
  output logic       frame_done,
  output logic       underrun
);

  localparam logic [10:0] CNT_MAX  = 11'd2047;
  localparam logic [10:0] MIN_CNT  = 11'(MIN_PAYLOAD);
  localparam logic [7:0]  IFG_LAST = 8'(IFG_BYTES - 1);
  localparam logic [2:0]  PRE_LAST = 3'd6;
  localparam logic [1:0]  FCS_LAST = 2'd3;

  tx_state_t   state_r, state_s;
  logic [2:0]  pre_cnt_r, pre_cnt_s;
  logic [10:0] byte_cnt_r, byte_cnt_s, byte_cnt_inc_s;
  logic [1:0]  fcs_idx_r, fcs_idx_s;
  logic [7:0]  ifg_cnt_r, ifg_cnt_s;
  logic [31:0] crc_r, crc_s, crc_calc_s, crc_inv_s;
  logic [7:0]  crc_data_s, fcs_byte_s;
  logic        frame_ok_r, frame_ok_s;
  logic [7:0]  txd_s;
  logic        txen_s, txer_s, done_s, urun_s;

  // Payload is only pulled from upstream while in DATA.
  assign txready   = (state_r == ST_DATA);
  assign crc_inv_s = ~crc_r;

  crc32_d8 u_crc (
    .crc_in  (crc_r),
    .data    (crc_data_s),
    .crc_out (crc_calc_s)
  );

  // CRC input byte: upstream data in DATA, zero pad otherwise.
  always_comb begin
    if (state_r == ST_DATA) begin
      crc_data_s = txdata;
    end else begin
      crc_data_s = 8'h00;
    end
  end

  // Saturating payload byte count increment.
  always_comb begin
    if (byte_cnt_r == CNT_MAX) begin
      byte_cnt_inc_s = CNT_MAX;
    end else begin
      byte_cnt_inc_s = byte_cnt_r + 11'd1;
    end
  end

  // Select the FCS byte, least significant byte first.
  always_comb begin
    case (fcs_idx_r)
      2'd0:    fcs_byte_s = crc_inv_s[7:0];
      2'd1:    fcs_byte_s = crc_inv_s[15:8];
      2'd2:    fcs_byte_s = crc_inv_s[23:16];
      2'd3:    fcs_byte_s = crc_inv_s[31:24];
      default: fcs_byte_s = 8'h00;
    endcase
  end

  // Next-state, counter and registered-output decisions.
  always_comb begin
    state_s    = state_r;
    pre_cnt_s  = pre_cnt_r;
    byte_cnt_s = byte_cnt_r;
    fcs_idx_s  = fcs_idx_r;
    ifg_cnt_s  = ifg_cnt_r;
    crc_s      = crc_r;
    frame_ok_s = frame_ok_r;
    txd_s      = 8'h00;
    txen_s     = 1'b0;
    txer_s     = 1'b0;
    done_s     = 1'b0;
    urun_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        byte_cnt_s = 11'd0;
        if (txvalid) begin
          state_s   = ST_PRE;
          pre_cnt_s = 3'd0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_PRE: begin
        txd_s  = PREAMBLE_BYTE;
        txen_s = 1'b1;
        if (pre_cnt_r == PRE_LAST) begin
          state_s   = ST_SFD;
          pre_cnt_s = 3'd0;
        end else begin
          pre_cnt_s = pre_cnt_r + 3'd1;
        end
      end
      ST_SFD: begin
        txd_s      = SFD_BYTE;
        txen_s     = 1'b1;
        crc_s      = CRC_INIT;
        byte_cnt_s = 11'd0;
        state_s    = ST_DATA;
      end
      ST_DATA: begin
        txen_s = 1'b1;
        if (txvalid) begin
          txd_s      = txdata;
          txer_s     = txerr;
          crc_s      = crc_calc_s;
          byte_cnt_s = byte_cnt_inc_s;
          if (txlast) begin
            fcs_idx_s = 2'd0;
            if (byte_cnt_inc_s < MIN_CNT) begin
              state_s = ST_PAD;
            end else begin
              state_s = ST_FCS;
            end
          end else begin
            state_s = ST_DATA;
          end
        end else begin
          // Upstream ran dry: poison the frame with one error byte, skip FCS.
          txd_s      = 8'h00;
          txer_s     = 1'b1;
          urun_s     = 1'b1;
          frame_ok_s = 1'b0;
          ifg_cnt_s  = 8'd0;
          state_s    = ST_IFG;
        end
      end
      ST_PAD: begin
        txd_s      = 8'h00;
        txen_s     = 1'b1;
        crc_s      = crc_calc_s;
        byte_cnt_s = byte_cnt_inc_s;
        if (byte_cnt_inc_s >= MIN_CNT) begin
          fcs_idx_s = 2'd0;
          state_s   = ST_FCS;
        end else begin
          state_s = ST_PAD;
        end
      end
      ST_FCS: begin
        txd_s  = fcs_byte_s;
        txen_s = 1'b1;
        if (fcs_idx_r == FCS_LAST) begin
          frame_ok_s = 1'b1;
          ifg_cnt_s  = 8'd0;
          state_s    = ST_IFG;
        end else begin
          fcs_idx_s = fcs_idx_r + 2'd1;
        end
      end
      ST_IFG: begin
        // First IFG decision lands on the first idle wire cycle.
        if (ifg_cnt_r == 8'd0) begin
          done_s = frame_ok_r;
        end else begin
          done_s = 1'b0;
        end
        if (ifg_cnt_r == IFG_LAST) begin
          ifg_cnt_s = 8'd0;
          if (txvalid) begin
            state_s   = ST_PRE;
            pre_cnt_s = 3'd0;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          ifg_cnt_s = ifg_cnt_r + 8'd1;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Counters, CRC accumulator and completion flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt_r  <= 3'd0;
      byte_cnt_r <= 11'd0;
      fcs_idx_r  <= 2'd0;
      ifg_cnt_r  <= 8'd0;
      crc_r      <= CRC_INIT;
      frame_ok_r <= 1'b0;
    end else begin
      pre_cnt_r  <= pre_cnt_s;
      byte_cnt_r <= byte_cnt_s;
      fcs_idx_r  <= fcs_idx_s;
      ifg_cnt_r  <= ifg_cnt_s;
      crc_r      <= crc_s;
      frame_ok_r <= frame_ok_s;
    end
  end

  // GMII outputs and status pulses, all registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gmiitxd    <= 8'h00;
      gmiitxen   <= 1'b0;
      gmiitxer   <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      gmiitxd    <= txd_s;
      gmiitxen   <= txen_s;
      gmiitxer   <= txer_s;
      frame_done <= done_s;
      underrun   <= urun_s;
    end
  end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Directed bench for gmii_tx_framer: drives payload frames, logs every wire
// cycle and checks framing, padding, FCS, IFG, error and reset behaviour.
module tb_gmii_tx_framer;

  logic       clk, reset;
  logic [7:0] txdata;
  logic       txvalid, txlast, txerr;
  logic       txready;
  logic [7:0] gmiitxd;
  logic       gmiitxen, gmiitxer, frame_done, underrun;

  int n_tests = 0;
  int n_fail  = 0;

  // Wire log entry: {underrun, frame_done, gmiitxer, gmiitxen, gmiitxd}
  logic [11:0] log_q[$];
  logic [7:0]  pay_q[$];

  gmii_tx_framer dut (
    .clk        (clk),
    .reset      (reset),
    .txdata     (txdata),
    .txvalid    (txvalid),
    .txlast     (txlast),
    .txerr      (txerr),
    .txready    (txready),
    .gmiitxd    (gmiitxd),
    .gmiitxen   (gmiitxen),
    .gmiitxer   (gmiitxer),
    .frame_done (frame_done),
    .underrun   (underrun)
  );

  // 125 MHz clock.
  always #4 clk = ~clk;

  // Capture outputs midway between rising edges.
  always @(negedge clk) begin
    log_q.push_back({underrun, frame_done, gmiitxer, gmiitxen, gmiitxd});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference CRC step, bit-serial form.
  function automatic logic [31:0] ref_crc(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    logic fb;
    r = c;
    for (int b = 0; b < 8; b++) begin
      fb = r[0] ^ d[b];
      r  = {1'b0, r[31:1]};
      if (fb) r = r ^ 32'hEDB88320;
    end
    return r;
  endfunction

  function automatic logic [11:0] lg(input int i);
    if (i >= 0 && i < log_q.size()) return log_q[i];
    return 12'h000;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fill(input int n, input int mul, input int add);
    pay_q.delete();
    for (int k = 0; k < n; k++) pay_q.push_back(8'((k * mul + add) & 255));
  endtask

  // Send pay_q[0..n-1]; with stop_at >= 0 only that many bytes, no txlast.
  task automatic send(input int n, input int stop_at, input int err_at);
    int  lim, w;
    bit  acc;
    lim = (stop_at >= 0) ? stop_at : n;
    for (int i = 0; i < lim; i++) begin
      txdata  = pay_q[i];
      txvalid = 1'b1;
      txlast  = (stop_at < 0) && (i == n - 1);
      txerr   = (i == err_at);
      acc = 1'b0;
      w   = 0;
      while (!acc && w < 100) begin
        @(negedge clk);
        acc = txready;
        @(posedge clk);
        #1;
        w++;
      end
      if (!acc) begin
        chk("accept_timeout", 32'(i), 32'(lim));
        break;
      end
    end
    txvalid = 1'b0;
    txlast  = 1'b0;
    txerr   = 1'b0;
  endtask

  task automatic find_run(input int from, output int s, output int len);
    logic [11:0] e;
    s = from;
    e = lg(s);
    while (s < log_q.size() && !e[8]) begin s++; e = lg(s); end
    len = 0;
    while (s + len < log_q.size() && e[8]) begin len++; e = lg(s + len); end
  endtask

  task automatic check_frame(input string tag, input int n, input int err_at, inout int pos);
    int s, len, np, bad, ner;
    logic [11:0] e, e0, e2;
    logic [7:0]  b;
    logic [31:0] c, r, fcs_w;
    find_run(pos, s, len);
    np = (n < 60) ? 60 : n;
    chk({tag, "_len"}, 32'(len), 32'(8 + np + 4));
    bad = 0;
    for (int k = 0; k < 7; k++) begin e = lg(s + k); if (e[7:0] != 8'h55) bad++; end
    chk({tag, "_preamble"}, 32'(bad), 32'd0);
    e = lg(s + 7);
    chk({tag, "_sfd"}, {24'd0, e[7:0]}, 32'h000000D5);
    bad = 0;
    c = 32'hFFFFFFFF;
    for (int k = 0; k < np; k++) begin
      b = (k < n) ? pay_q[k] : 8'h00;
      c = ref_crc(c, b);
      e = lg(s + 8 + k);
      if (e[7:0] != b) bad++;
    end
    chk({tag, "_payload"}, 32'(bad), 32'd0);
    fcs_w = 32'd0;
    for (int k = 0; k < 4; k++) begin e = lg(s + 8 + np + k); fcs_w[8*k +: 8] = e[7:0]; end
    chk({tag, "_fcs"}, fcs_w, ~c);
    r = 32'hFFFFFFFF;
    for (int k = 0; k < np + 4; k++) begin e = lg(s + 8 + k); r = ref_crc(r, e[7:0]); end
    chk({tag, "_residue"}, r, 32'hDEBB20E3);
    ner = 0;
    for (int k = 0; k < len; k++) begin e = lg(s + k); if (e[9]) ner++; end
    chk({tag, "_txer_cnt"}, 32'(ner), (err_at >= 0) ? 32'd1 : 32'd0);
    if (err_at >= 0) begin
      e = lg(s + 8 + err_at);
      chk({tag, "_txer_pos"}, {31'd0, e[9]}, 32'd1);
    end
    e0 = lg(s + len - 1);
    e  = lg(s + len);
    e2 = lg(s + len + 1);
    chk({tag, "_done"}, {29'd0, e0[10], e[10], e2[10]}, 32'd2);
    pos = s + len;
  endtask

  task automatic check_gap(input string tag, inout int pos);
    int g;
    logic [11:0] e;
    g = 0;
    e = lg(pos);
    while (pos + g < log_q.size() && !e[8]) begin g++; e = lg(pos + g); end
    chk(tag, 32'(g), 32'd12);
    pos = pos + g;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pos, s, len, nur, nfd, bad;
    logic [11:0] e;
    clk = 1'b0; reset = 1'b1;
    txdata = 8'h00; txvalid = 1'b0; txlast = 1'b0; txerr = 1'b0;

    // Reset state
    #18;
    chk("rst_outputs", {20'd0, txready, underrun, frame_done, gmiitxer, gmiitxen, gmiitxd}, 32'd0);
    @(negedge clk) reset = 1'b0;
    idle(4);
    chk("idle_outputs", {20'd0, txready, underrun, frame_done, gmiitxer, gmiitxen, gmiitxd}, 32'd0);

    // 1: 60-byte payload 0x00..0x3B, no padding
    log_q.delete();
    fill(60, 1, 0);
    send(60, -1, -1);
    idle(120);
    pos = 0;
    check_frame("t1", 60, -1, pos);

    // 2: 14-byte payload padded to 60
    log_q.delete();
    fill(14, 1, 8'hA0);
    send(14, -1, -1);
    idle(120);
    pos = 0;
    check_frame("t2", 14, -1, pos);

    // 3: back-to-back 64-byte frames, exact 12-cycle gap
    log_q.delete();
    fill(64, 7, 3);
    send(64, -1, -1);
    send(64, -1, -1);
    idle(120);
    pos = 0;
    check_frame("t3a", 64, -1, pos);
    check_gap("t3_gap", pos);
    check_frame("t3b", 64, -1, pos);

    // 4: underrun after 20 bytes, then a frame queued during the gap
    log_q.delete();
    fill(40, 11, 5);
    send(40, 20, -1);
    idle(2);
    txvalid = 1'b1;
    fill(16, 3, 8'h5A);
    send(16, -1, -1);
    idle(120);
    find_run(0, s, len);
    chk("t4_len", 32'(len), 32'd29);
    e = lg(s + len - 1);
    chk("t4_errbyte", {20'd0, e}, 32'h00000B00);
    fill(40, 11, 5);
    bad = 0;
    for (int k = 0; k < 20; k++) begin e = lg(s + 8 + k); if (e[7:0] != pay_q[k]) bad++; end
    chk("t4_payload", 32'(bad), 32'd0);
    nur = 0; nfd = 0;
    for (int k = 0; k < s + len + 12; k++) begin
      e = lg(k);
      if (e[11]) nur++;
      if (e[10]) nfd++;
    end
    chk("t4_underrun_cnt", 32'(nur), 32'd1);
    chk("t4_no_done", 32'(nfd), 32'd0);
    pos = s + len;
    check_gap("t4_gap", pos);
    fill(16, 3, 8'h5A);
    check_frame("t4b", 16, -1, pos);

    // 5: txerr on payload byte 5
    log_q.delete();
    fill(60, 13, 1);
    send(60, -1, 5);
    idle(120);
    pos = 0;
    check_frame("t5", 60, 5, pos);

    // 6: asynchronous reset at payload byte 30, then a clean frame
    fill(60, 1, 0);
    send(60, 30, -1);
    chk("t6_txen_before", {31'd0, gmiitxen}, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("t6_async_clear", {20'd0, txready, underrun, frame_done, gmiitxer, gmiitxen, gmiitxd}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    log_q.delete();
    idle(2);
    fill(60, 1, 100);
    send(60, -1, -1);
    idle(120);
    nur = 0;
    for (int k = 0; k < log_q.size(); k++) begin e = lg(k); if (e[11]) nur++; end
    chk("t6_no_underrun", 32'(nur), 32'd0);
    pos = 0;
    check_frame("t6", 60, -1, pos);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
